pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter BOX_SIZE, default 64, giving the bouncing-box edge length in pixels (range 8..256).
REQ-002 SHALL have parameter BOX_SPEED, default 2, giving the box displacement per frame per axis in pixels (range 1..16).
REQ-003 SHALL have port clk_pix  in  1  pixel clock; the only clock.
REQ-004 SHALL have port rst_pix  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port RES  in  2  resolution select: 00=640x480, 01=1280x720, 10=1920x1080, 11=640x480.
REQ-006 SHALL have port mode  in  2  pattern select: 0=colour bars, 1=checkerboard, 2=bouncing box, 3=solid white.
REQ-007 SHALL have port sx  in  12  current pixel column from the timing generator.
REQ-008 SHALL have port sy  in  12  current pixel line from the timing generator.
REQ-009 SHALL have port hsync  in  1  active-low horizontal sync from the timing generator.
REQ-010 SHALL have port vsync  in  1  active-low vertical sync from the timing generator.
REQ-011 SHALL have port de  in  1  active-video flag from the timing generator.
REQ-012 SHALL have ports r, g, b  out  8 each  registered pixel colour.
REQ-013 SHALL have ports hsync_o, vsync_o, de_o  out  1 each  registered, delayed copies of hsync, vsync and de.
REQ-014 SHALL have port frame_cnt  out  16  count of frame starts since reset.

Function
REQ-015 SHALL produce all outputs from a fixed 2-stage pipeline: the input sample at cycle N appears on r/g/b/hsync_o/vsync_o/de_o at cycle N+2.
REQ-016 SHALL define a frame-start event as an input sample with sx==0 and sy==0.
REQ-017 SHALL latch mode into mode_q and RES into res_q on a frame-start event; changes to mode or RES mid-frame SHALL take effect only from the next frame start.
REQ-018 SHALL apply the new mode_q to the frame-start pixel itself.
REQ-019 SHALL set the active width W and height H from res_q: 640/480, 1280/720 or 1920/1080.
REQ-020 SHALL increment frame_cnt by 1 on each frame-start event, wrapping from 0xFFFF to 0x0000.
REQ-021 Colour bars SHALL form 8 equal bars of width W/8, indexed by the first k with sx < (k+1)*W/8.
REQ-022 The bar order SHALL be white, yellow, cyan, green, magenta, red, blue, black, with each channel at 0xFF or 0x00.
REQ-023 Checkerboard SHALL output white (FF,FF,FF) when sx[5]^sy[5]==1 and black (00,00,00) otherwise.
REQ-024 Bouncing box SHALL output red (FF,00,00) when box_x<=sx<box_x+BOX_SIZE and box_y<=sy<box_y+BOX_SIZE, and background (00,00,80) otherwise.
REQ-025 Box-position state SHALL consist of box_x and box_y (12 bits each) and per-axis direction bits dir_x and dir_y (1=increasing).
REQ-026 The box position SHALL update once per frame-start event, after the frame-start pixel has been evaluated, so that the position is constant across an entire frame.
REQ-027 On each box update, the candidate position SHALL be box ± BOX_SPEED, computed in 13-bit signed arithmetic.
REQ-028 If the candidate exceeds W-BOX_SIZE (or H-BOX_SIZE), the box SHALL clamp to that limit and clear the axis direction bit.
REQ-029 If the candidate is below 0, the box SHALL clamp to 0 and set the axis direction bit.
REQ-030 After a change to a smaller RES, an out-of-range box SHALL be clamped at the next update by the same rule.
REQ-031 Solid white SHALL output FF,FF,FF.
REQ-032 r, g and b SHALL be 00 whenever de_o==0, regardless of mode.
REQ-033 The box position, frame_cnt, mode_q and res_q SHALL update only on frame-start events; the box SHALL update only while mode_q==2 and SHALL hold otherwise.

Reset
REQ-034 While rst_pix=1 at a clock edge, the block SHALL set r=g=b=00, de_o=0, hsync_o=1, vsync_o=1, frame_cnt=0, mode_q=0, res_q=00, box_x=box_y=0 and dir_x=dir_y=1.
REQ-035 SHALL flush both pipeline stages on reset, so that de_o stays 0 for the first 2 cycles after rst_pix falls.
REQ-036 Reset asserted mid-frame SHALL take priority over every other update, including a simultaneous frame-start event.

Verification
REQ-037 Colour-bar check: RES=00, mode=0, full frame -> at sx=0 output FFFFFF; at sx=80 output FFFF00; at sx=639 output 000000; all appear 2 cycles after the input sample.
REQ-038 Pipeline/sync check: a single-cycle hsync low pulse at cycle N -> hsync_o low at exactly cycle N+2; de=0 -> r/g/b=00.
REQ-039 Mode latch check: mode changes 0->1 at sy=100 -> bars continue to frame end; the checkerboard starts at the next sx=0,sy=0 pixel; frame_cnt increments at that point.
REQ-040 Box bounce check: RES=00, mode=2, BOX_SIZE=64, BOX_SPEED=2, 289 frames -> box_x reaches 576 (clamp at 640-64) and dir_x clears; the next frame box_x=574.
REQ-041 Wrap check: frame_cnt preloaded to 0xFFFF by running frames, then one more frame start -> frame_cnt=0x0000.
REQ-042 Reset check: assert rst_pix mid-frame coincident with a frame start -> all REQ-034 values hold; de_o=0 for 2 cycles after release; frame_cnt=0 until the next frame start.

Source files
------------

// File: rtl/pattern_gen.sv
// Video test-pattern generator.
// Takes raster coordinates and syncs from a timing generator and produces a
// registered RGB pixel, two cycles behind the input sample. Four patterns:
// colour bars, checkerboard, a bouncing box and solid white. The pattern and
// resolution are latched once per frame so that a frame is never torn.
module pattern_gen #(
    parameter int BOX_SIZE  = 64,
    parameter int BOX_SPEED = 2
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic [1:0]  RES,
    input  logic [1:0]  mode,
    input  logic [11:0] sx,
    input  logic [11:0] sy,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] MODE_BARS    = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_BOX     = 2'd2;
    localparam logic [1:0] MODE_WHITE   = 2'd3;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_RED   = 24'hFF0000;
    localparam logic [23:0] RGB_BKGND = 24'h000080;

    // Per-frame configuration and box state
    logic [1:0]  mode_q;
    logic [1:0]  res_q;
    logic [11:0] box_x;
    logic [11:0] box_y;
    logic        dir_x;
    logic        dir_y;

    // Pipeline stage 1
    logic [23:0] rgb_s1;
    logic        hs_s1;
    logic        vs_s1;
    logic        de_s1;

    // Combinational helpers
    logic        frame_start;
    logic [1:0]  mode_eff;
    logic [1:0]  res_eff;
    logic [12:0] width;
    logic [12:0] height;
    logic [12:0] bar_w;
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;
    logic        in_box;
    logic [23:0] pix_rgb;
    logic signed [12:0] cand_x;
    logic signed [12:0] cand_y;
    logic signed [12:0] lim_x;
    logic signed [12:0] lim_y;
    logic [11:0] next_x;
    logic [11:0] next_y;
    logic        next_dir_x;
    logic        next_dir_y;

    // The frame-start pixel already uses the mode/resolution being latched on it.
    assign frame_start = (sx == 12'd0) && (sy == 12'd0);
    assign mode_eff    = frame_start ? mode : mode_q;
    assign res_eff     = frame_start ? RES  : res_q;

    // Active area size for the selected resolution
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        width  = 13'd640;
        height = 13'd480;
        case (res_eff)
            2'b01:   begin width = 13'd1280; height = 13'd720;  end
            2'b10:   begin width = 13'd1920; height = 13'd1080; end
            default: begin width = 13'd640;  height = 13'd480;  end
        endcase
    end

    assign bar_w = width >> 3;

    // Colour-bar index: first bar whose right edge lies beyond sx
    always_comb begin
        bar_idx = 3'd7;
        for (int k = 7; k >= 0; k--) begin
            if ({1'b0, sx} < bar_w * 13'(k + 1))
                bar_idx = 3'(k);
        end
    end

    // Bar index to colour: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        bar_rgb = RGB_BLACK;
        case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign in_box = ({1'b0, sx} >= {1'b0, box_x}) &&
                    ({1'b0, sx} <  {1'b0, box_x} + 13'(BOX_SIZE)) &&
                    ({1'b0, sy} >= {1'b0, box_y}) &&
                    ({1'b0, sy} <  {1'b0, box_y} + 13'(BOX_SIZE));

    // Pattern select for the current sample
    always_comb begin
        pix_rgb = RGB_BLACK;
        case (mode_eff)
            MODE_BARS:    pix_rgb = bar_rgb;
            MODE_CHECKER: pix_rgb = (sx[5] ^ sy[5]) ? RGB_WHITE : RGB_BLACK;
            MODE_BOX:     pix_rgb = in_box ? RGB_RED : RGB_BKGND;
            MODE_WHITE:   pix_rgb = RGB_WHITE;
            default:      pix_rgb = RGB_BLACK;
        endcase
    end

    // Next box position: step, then clamp into [0, size-BOX_SIZE] and bounce
    always_comb begin
        lim_x  = width  - 13'(BOX_SIZE);
        lim_y  = height - 13'(BOX_SIZE);
        cand_x = dir_x ? ({1'b0, box_x} + 13'(BOX_SPEED)) : ({1'b0, box_x} - 13'(BOX_SPEED));
        cand_y = dir_y ? ({1'b0, box_y} + 13'(BOX_SPEED)) : ({1'b0, box_y} - 13'(BOX_SPEED));
        next_x = cand_x[11:0];
        next_y = cand_y[11:0];
        next_dir_x = dir_x;
        next_dir_y = dir_y;
        if (cand_x > lim_x) begin
            next_x     = lim_x[11:0];
            next_dir_x = 1'b0;
        end else if (cand_x < 13'sd0) begin
            next_x     = 12'd0;
            next_dir_x = 1'b1;
        end
        if (cand_y > lim_y) begin
            next_y     = lim_y[11:0];
            next_dir_y = 1'b0;
        end else if (cand_y < 13'sd0) begin
            next_y     = 12'd0;
            next_dir_y = 1'b1;
        end
    end

    // Per-frame state: latch config, count frames, move the box
    always_ff @(posedge clk_pix) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_pix) begin
            mode_q    <= MODE_BARS;
            res_q     <= 2'b00;
            frame_cnt <= 16'd0;
            box_x     <= 12'd0;
            box_y     <= 12'd0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
        end else if (frame_start) begin
            mode_q    <= mode;
            res_q     <= RES;
            frame_cnt <= frame_cnt + 16'd1;
            if (mode == MODE_BOX) begin
                box_x <= next_x;
                box_y <= next_y;
                dir_x <= next_dir_x;
                dir_y <= next_dir_y;
            end
        end
    end

    // Two-stage output pipeline; colour is blanked outside active video
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            rgb_s1  <= RGB_BLACK;
            hs_s1   <= 1'b1;
            vs_s1   <= 1'b1;
            de_s1   <= 1'b0;
            r       <= 8'h00;
            g       <= 8'h00;
            b       <= 8'h00;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            de_o    <= 1'b0;
        end else begin
            rgb_s1  <= pix_rgb;
            hs_s1   <= hsync;
            vs_s1   <= vsync;
            de_s1   <= de;
            r       <= de_s1 ? rgb_s1[23:16] : 8'h00;
            g       <= de_s1 ? rgb_s1[15:8]  : 8'h00;
            b       <= de_s1 ? rgb_s1[7:0]   : 8'h00;
            hsync_o <= hs_s1;
            vsync_o <= vs_s1;
            de_o    <= de_s1;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed testbench for pattern_gen. Frames are compressed: a frame start is
// a single sx=0,sy=0 sample, and only the pixels of interest are driven.
module tb_pattern_gen;

    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic [1:0]  RES;
    logic [1:0]  mode;
    logic [11:0] sx;
    logic [11:0] sy;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic [15:0] frame_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_fc = 16'd0;

    pattern_gen #(.BOX_SIZE(64), .BOX_SPEED(2)) dut (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .RES       (RES),
        .mode      (mode),
        .sx        (sx),
        .sy        (sy),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .r         (r),
        .g         (g),
        .b         (b),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .de_o      (de_o),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Drive one input sample; frame starts are tracked in the expected count.
    task automatic drive(input logic [11:0] x, input logic [11:0] y,
                         input logic d, input logic hs, input logic vs);
        sx = x; sy = y; de = d; hsync = hs; vsync = vs;
        if (!rst_pix && x == 12'd0 && y == 12'd0)
            exp_fc = exp_fc + 16'd1;
    endtask

    task automatic idle();
        sx = 12'hFFF; sy = 12'hFFF; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    endtask

    // Drive an active pixel and check its colour two cycles later.
    task automatic probe(input string tag, input logic [11:0] x, input logic [11:0] y,
                         input logic [23:0] exp);
        drive(x, y, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        check(tag, {8'h00, r, g, b}, {8'h00, exp});
    endtask

    initial begin
        rst_pix = 1'b1;
        RES = 2'b00;
        mode = 2'd0;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_rgb",   {8'h00, r, g, b}, 32'h0);
        check("rst_de_o",  de_o, 1'b0);
        check("rst_hs_o",  hsync_o, 1'b1);
        check("rst_vs_o",  vsync_o, 1'b1);
        check("rst_fcnt",  frame_cnt, 16'd0);
        check("rst_box_x", dut.box_x, 12'd0);
        check("rst_dir_x", dut.dir_x, 1'b1);
        rst_pix = 1'b0;

        // Colour bars at 640x480
        probe("bar_sx0",   12'd0,   12'd0, 24'hFFFFFF);
        check("fcnt_1",    frame_cnt, exp_fc);
        probe("bar_sx79",  12'd79,  12'd1, 24'hFFFFFF);
        probe("bar_sx80",  12'd80,  12'd1, 24'hFFFF00);
        probe("bar_sx320", 12'd320, 12'd1, 24'hFF00FF);
        probe("bar_sx639", 12'd639, 12'd1, 24'h000000);

        // Sync pipeline: single-cycle hsync low shows up exactly two cycles later
        drive(12'd10, 12'd10, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        check("hs_n1", hsync_o, 1'b1);
        tick();
        check("hs_n2", hsync_o, 1'b0);
        tick();
        check("hs_n3", hsync_o, 1'b1);

        // Blanking forces black
        drive(12'd10, 12'd10, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        check("blank_rgb", {8'h00, r, g, b}, 32'h0);
        check("blank_de",  de_o, 1'b0);

        // Mode change mid-frame waits for the next frame start
        mode = 2'd1;
        probe("latch_mid", 12'd80, 12'd100, 24'hFFFF00);
        check("latch_fcnt_hold", frame_cnt, exp_fc);
        probe("chk_sx0",   12'd0,  12'd0,  24'h000000);
        check("latch_fcnt_inc", frame_cnt, 16'd2);
        probe("chk_32_0",  12'd32, 12'd0,  24'hFFFFFF);
        probe("chk_32_32", 12'd32, 12'd32, 24'h000000);

        // Bars at other resolutions
        mode = 2'd0;
        RES = 2'b01;
        probe("r720_sx0",   12'd0,    12'd0, 24'hFFFFFF);
        probe("r720_159",   12'd159,  12'd1, 24'hFFFFFF);
        probe("r720_160",   12'd160,  12'd1, 24'hFFFF00);
        RES = 2'b10;
        probe("r1080_sx0",  12'd0,    12'd0, 24'hFFFFFF);
        probe("r1080_240",  12'd240,  12'd1, 24'hFFFF00);
        probe("r1080_1919", 12'd1919, 12'd1, 24'h000000);
        RES = 2'b11;
        probe("r11_sx0",    12'd0,    12'd0, 24'hFFFFFF);
        probe("r11_80",     12'd80,   12'd1, 24'hFFFF00);

        // Solid white
        mode = 2'd3;
        probe("white_sx0", 12'd0,   12'd0, 24'hFFFFFF);
        probe("white_mid", 12'd500, 12'd9, 24'hFFFFFF);

        // Bouncing box: 289 frames -> x clamps at 576, y is on its way back at 256
        mode = 2'd2;
        RES = 2'b00;
        for (int i = 0; i < 289; i++) begin
            drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
            tick();
        end
        idle();
        check("box_x_289", dut.box_x, 12'd576);
        check("dir_x_289", dut.dir_x, 1'b0);
        check("box_y_289", dut.box_y, 12'd256);
        drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        check("box_x_290", dut.box_x, 12'd574);
        check("box_y_290", dut.box_y, 12'd254);
        probe("box_left_in",   12'd574, 12'd254, 24'hFF0000);
        probe("box_left_out",  12'd573, 12'd254, 24'h000080);
        probe("box_right_in",  12'd637, 12'd317, 24'hFF0000);
        probe("box_right_out", 12'd638, 12'd254, 24'h000080);
        probe("box_top_out",   12'd574, 12'd253, 24'h000080);
        check("box_fcnt", frame_cnt, exp_fc);

        // Frame counter wrap
        mode = 2'd0;
        while (exp_fc != 16'hFFFF) begin
            drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
            tick();
        end
        check("fcnt_ffff", frame_cnt, 16'hFFFF);
        drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        check("fcnt_wrap", frame_cnt, 16'h0000);

        // Move the box so reset has something to clear
        mode = 2'd2;
        drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();

        // Reset coincident with a frame start wins
        rst_pix = 1'b1;
        mode = 2'd3;
        RES = 2'b10;
        drive(12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_fc = 16'd0;
        check("rr_rgb",   {8'h00, r, g, b}, 32'h0);
        check("rr_de_o",  de_o, 1'b0);
        check("rr_hs_o",  hsync_o, 1'b1);
        check("rr_vs_o",  vsync_o, 1'b1);
        check("rr_fcnt",  frame_cnt, 16'd0);
        check("rr_mode_q", dut.mode_q, 2'd0);
        check("rr_res_q",  dut.res_q, 2'b00);
        check("rr_box",   {dut.box_x, dut.box_y}, 24'd0);
        check("rr_dirs",  {dut.dir_x, dut.dir_y}, 2'b11);
        rst_pix = 1'b0;
        drive(12'd5, 12'd5, 1'b1, 1'b1, 1'b1);
        check("rr_de_c0", de_o, 1'b0);
        tick();
        check("rr_de_c1", de_o, 1'b0);
        tick();
        check("rr_de_c2", de_o, 1'b1);
        check("rr_fcnt_hold", frame_cnt, 16'd0);
        probe("rr_next_fs", 12'd0, 12'd0, 24'hFFFFFF);
        check("rr_fcnt_inc", frame_cnt, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
